// File: rtl/xcorr_ssp_deframer.sv
// SSP deframer for the HF cross-correlator stream: recovers framed bytes, pairs them
// into signed I/Q samples with an approximate magnitude, and queues them in a small FIFO.
module xcorr_ssp_deframer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ssp_clk,
    input  logic                 ssp_frame,
    input  logic                 ssp_din,
    input  logic                 snoop,
    input  logic                 resync,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_i,
    output logic [7:0]           out_q,
    output logic [8:0]           out_mag,
    output logic [1:0]           out_reader,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] frame_err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {HUNT, SHIFT} state_t;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
        logic [8:0] mag;
        logic [1:0] reader;
    } sample_t;

    logic [2:0] sync_q [SYNC_STAGES];
    logic       sclk_prev;
    logic       s_clk, s_frame, s_din, sample;

    assign {s_clk, s_frame, s_din} = sync_q[SYNC_STAGES-1];
    assign sample = sclk_prev & ~s_clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sync_q[0] <= {ssp_clk, ssp_frame, ssp_din};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            sclk_prev <= s_clk;
        end
    end

    state_t     state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [3:0] bitcnt, bitcnt_nxt;
    logic       after_byte, after_byte_nxt;
    logic       byte_done, frame_err, sel_clear;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt      = state;
        shreg_nxt      = shreg;
        bitcnt_nxt     = bitcnt;
        after_byte_nxt = after_byte;
        byte_done      = 1'b0;
        frame_err      = 1'b0;
        sel_clear      = 1'b0;
        if (resync) begin
            state_nxt      = HUNT;
            bitcnt_nxt     = 4'd0;
            after_byte_nxt = 1'b0;
            sel_clear      = 1'b1;
        end else if (sample) begin
            unique case (state)
                HUNT: begin
                    after_byte_nxt = 1'b0;
                    if (s_frame) begin
                        shreg_nxt  = {7'b0, s_din};
                        bitcnt_nxt = 4'd1;
                        state_nxt  = SHIFT;
                    end else begin
                        frame_err = after_byte;
                    end
                end
                SHIFT: begin
                    if (s_frame) begin
                        // Early frame: abandon the partial byte and any half-built pair.
                        frame_err  = 1'b1;
                        sel_clear  = 1'b1;
                        shreg_nxt  = {7'b0, s_din};
                        bitcnt_nxt = 4'd1;
                    end else begin
                        shreg_nxt  = {shreg[6:0], s_din};
                        bitcnt_nxt = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            byte_done      = 1'b1;
                            after_byte_nxt = 1'b1;
                            state_nxt      = HUNT;
                        end
                    end
                end
            endcase
        end
    end

    logic       byte_sel_q;
    logic [7:0] i_byte, pend_i, pend_q;
    logic       pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            shreg         <= '0;
            bitcnt        <= '0;
            after_byte    <= 1'b0;
            byte_sel_q    <= 1'b0;
            i_byte        <= '0;
            pend_i        <= '0;
            pend_q        <= '0;
            pend_valid    <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bitcnt     <= bitcnt_nxt;
            after_byte <= after_byte_nxt;
            pend_valid <= 1'b0;
            if (sel_clear) begin
                byte_sel_q <= 1'b0;
            end else if (byte_done) begin
                if (!byte_sel_q) begin
                    i_byte     <= shreg_nxt;
                    byte_sel_q <= 1'b1;
                end else begin
                    pend_i     <= i_byte;
                    pend_q     <= shreg_nxt;
                    pend_valid <= 1'b1;
                    byte_sel_q <= 1'b0;
                end
            end
            if (frame_err && frame_err_cnt != '1)
                frame_err_cnt <= frame_err_cnt + ERR_CNT_W'(1);
        end
    end

    logic [7:0] fmt_i, fmt_q, abs_i, abs_q, mx, mn;
    sample_t    push_data;

    always_comb begin
        fmt_i = snoop ? {pend_i[7], pend_i[7:1]} : pend_i;
        fmt_q = snoop ? {pend_q[7], pend_q[7:1]} : pend_q;
        // Two's-complement negate on 8 bits leaves -128 as 0x80, read as unsigned 128.
        abs_i = fmt_i[7] ? (~fmt_i + 8'd1) : fmt_i;
        abs_q = fmt_q[7] ? (~fmt_q + 8'd1) : fmt_q;
        mx    = (abs_i >= abs_q) ? abs_i : abs_q;
        mn    = (abs_i >= abs_q) ? abs_q : abs_i;
        push_data.i      = fmt_i;
        push_data.q      = fmt_q;
        push_data.mag    = {1'b0, mx} + {2'b00, mn[7:1]};
        push_data.reader = snoop ? {pend_i[0], pend_q[0]} : 2'b00;
    end

    sample_t       mem [FIFO_DEPTH];
    sample_t       head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = pend_valid & (~full | pop);

    // NOTE: storage is not reset; outputs are gated by out_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
            if (pend_valid && full && !pop) overflow <= 1'b1;
        end
    end

    assign head       = mem[rd_ptr];
    assign out_i      = out_valid ? head.i      : '0;
    assign out_q      = out_valid ? head.q      : '0;
    assign out_mag    = out_valid ? head.mag    : '0;
    assign out_reader = out_valid ? head.reader : '0;

endmodule

// File: tb/tb_xcorr_ssp_deframer.sv
// Scoreboard bench for xcorr_ssp_deframer: a bit-stream reference model queues expected
// samples, and an independent monitor pops and compares on every handshake.
module tb_xcorr_ssp_deframer;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int ERRW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ssp_clk = 1'b0, ssp_frame = 1'b0, ssp_din = 1'b0;
    logic            snoop = 1'b0, resync = 1'b0, out_ready = 1'b0;
    logic            out_valid, overflow;
    logic [7:0]      out_i, out_q;
    logic [8:0]      out_mag;
    logic [1:0]      out_reader;
    logic [ERRW-1:0] frame_err_cnt;

    always #5 clk = ~clk;

    xcorr_ssp_deframer #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ERR_CNT_W(ERRW)) dut (
        .clk(clk), .rst(rst), .ssp_clk(ssp_clk), .ssp_frame(ssp_frame), .ssp_din(ssp_din),
        .snoop(snoop), .resync(resync), .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_mag(out_mag), .out_reader(out_reader),
        .overflow(overflow), .frame_err_cnt(frame_err_cnt)
    );

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
        logic [8:0] mag;
        logic [1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0, pops = 0;
    int   ready_mode = 1;   // 0 = low, 1 = high, 2 = random
    bit   hold = 0;

    // Reference model state: bits collected since the last frame, pairing and error tallies.
    bit         m_inbyte, m_after, m_sel_q, m_ovf;
    int         m_bits, m_err;
    logic [7:0] m_sh, m_ibyte;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t make_pair(input logic [7:0] ib, input logic [7:0] qb, input bit snp);
        int   iv, qv, a, b;
        exp_t e;
        iv = int'($signed(ib));
        qv = int'($signed(qb));
        if (snp) begin
            iv = iv >>> 1;
            qv = qv >>> 1;
        end
        a = (iv < 0) ? -iv : iv;
        b = (qv < 0) ? -qv : qv;
        e.i   = 8'(iv);
        e.q   = 8'(qv);
        e.mag = 9'(((a > b) ? a : b) + ((a > b) ? b : a) / 2);
        e.rd  = snp ? {ib[0], qb[0]} : 2'b00;
        return e;
    endfunction

    function automatic void model_reset();
        m_inbyte = 0; m_after = 0; m_sel_q = 0; m_ovf = 0; m_bits = 0; m_err = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_sel_q) begin
            m_ibyte = b;
            m_sel_q = 1;
        end else begin
            m_sel_q = 0;
            if (hold && exp_q.size() >= DEPTH) m_ovf = 1;
            else exp_q.push_back(make_pair(m_ibyte, b, snoop));
        end
    endfunction

    function automatic void model_bit(input bit f, input bit d);
        if (!m_inbyte) begin
            if (f) begin
                m_sh = {7'b0, d}; m_bits = 1; m_inbyte = 1;
            end else if (m_after && m_err < 255) begin
                m_err++;
            end
            m_after = 0;
        end else if (f) begin
            if (m_err < 255) m_err++;
            m_sh = {7'b0, d}; m_bits = 1; m_sel_q = 0;
        end else begin
            m_sh = {m_sh[6:0], d}; m_bits++;
        end
        if (m_inbyte && m_bits == 8) begin
            m_inbyte = 0;
            m_after  = 1;
            model_byte(m_sh);
        end
    endfunction

    task automatic send_bit(input bit f, input bit d, input bit meas);
        int lat;
        @(negedge clk);
        ssp_clk = 1'b1; ssp_frame = f; ssp_din = d;
        model_bit(f, d);
        repeat (5) @(negedge clk);
        ssp_clk = 1'b0;
        if (meas) begin
            lat = 0;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
            check("latency", lat, SYNC + 2);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit meas_last);
        for (int k = 7; k >= 0; k--) send_bit(k == 7, b[k], meas_last && k == 0);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) send_bit(k == 0, b[7-k], 1'b0);
    endtask

    task automatic send_junk(input int n);
        for (int k = 0; k < n; k++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic pulse_resync();
        @(negedge clk); resync = 1'b1;
        m_inbyte = 0; m_sel_q = 0; m_after = 0;
        @(negedge clk); resync = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d samples outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  out_valid,     0);
        check({tag, "_i"},      out_i,         0);
        check({tag, "_q"},      out_q,         0);
        check({tag, "_mag"},    out_mag,       0);
        check({tag, "_reader"}, out_reader,    0);
        check({tag, "_ovf"},    overflow,      0);
        check({tag, "_errcnt"}, frame_err_cnt, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pop: got i=0x%0h q=0x%0h, expected no sample", out_i, out_q);
                end else begin
                    e = exp_q.pop_front();
                    check("out_i",      out_i,      e.i);
                    check("out_q",      out_q,      e.q);
                    check("out_mag",    out_mag,    e.mag);
                    check("out_reader", out_reader, e.rd);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        model_reset();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // Plain format, with latency measured on the Q byte's last bit.
        snoop = 1'b0;
        send_byte(8'h9C, 1'b0);
        send_byte(8'h23, 1'b1);
        wait_drain();

        // Snoop format with reader bits.
        snoop = 1'b1;
        send_byte(8'h81, 1'b0);
        send_byte(8'h7E, 1'b0);
        wait_drain();
        snoop = 1'b0;

        // Most negative values give the largest magnitude.
        send_byte(8'h80, 1'b0);
        send_byte(8'h80, 1'b0);
        wait_drain();

        // Six pairs into a four-entry FIFO with the consumer stalled.
        ready_mode = 0;
        hold = 1;
        for (int n = 0; n < 6; n++) begin
            send_byte(8'($urandom), 1'b0);
            send_byte(8'($urandom), 1'b0);
        end
        repeat (20) @(negedge clk);
        check("ovf_set",    overflow,  m_ovf);
        check("full_valid", out_valid, 1);
        p0 = pops;
        ready_mode = 1;
        repeat (20) @(negedge clk);
        check("pop_count",   pops - p0, DEPTH);
        check("drain_valid", out_valid, 0);
        hold = 0;
        wait_drain();

        // Early frame at bit 5, then a frameless byte after a completed one.
        send_partial(8'hA5, 4);
        send_byte(8'h3C, 1'b0);
        check("err_early_frame", frame_err_cnt, m_err);
        send_byte(8'hC4, 1'b0);
        send_junk(8);
        check("err_no_frame", frame_err_cnt, m_err);
        send_byte(8'h11, 1'b0);
        send_byte(8'hEE, 1'b0);
        wait_drain();

        // resync drops a lone I byte.
        send_byte(8'h55, 1'b0);
        pulse_resync();
        send_byte(8'h7F, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_drain();

        // Reset in the middle of a Q byte.
        send_byte(8'h42, 1'b0);
        send_partial(8'hF0, 4);
        @(negedge clk); rst = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_reset_outputs("midreset");
        end
        @(negedge clk); rst = 1'b0;
        send_byte(8'hD8, 1'b0);
        send_byte(8'h28, 1'b0);
        wait_drain();

        // Randomized traffic with junk, partial bytes and resyncs mixed in.
        ready_mode = 2;
        for (int blk = 0; blk < 3; blk++) begin
            snoop = 1'($urandom_range(0, 1));
            for (int n = 0; n < 8; n++) begin
                case ($urandom_range(0, 9))
                    0: send_junk($urandom_range(1, 12));
                    1: pulse_resync();
                    2: send_partial(8'($urandom), $urandom_range(1, 7));
                    default: ;
                endcase
                send_byte(8'($urandom), 1'b0);
                send_byte(8'($urandom), 1'b0);
            end
            wait_drain();
        end

        check("final_errcnt", frame_err_cnt, m_err);
        check("final_ovf",    overflow,      m_ovf);
        check("final_valid",  out_valid,     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xcorr_ssp_deframer.md
Name: xcorr_ssp_deframer

Overview:
- Downstream consumer of the HF cross-correlator's SSP stream (ssp_clk, ssp_frame, ssp_din), placed on the fabric-side system clock.
- Oversamples the SSP lines and recovers MSB-first bytes aligned by ssp_frame.
- Pairs the bytes into signed I/Q correlation samples, extracts the reader-AM bits in snoop mode, computes an approximate magnitude, and buffers results in a small ready/valid FIFO for the on-chip BPSK decoder.

Parameters:
- FIFO_DEPTH, 4, number of output entries; power of 2, at least 2.
- SYNC_STAGES, 2, flip-flop synchronizer depth on ssp_clk, ssp_frame and ssp_din.
- ERR_CNT_W, 8, width of the saturating framing-error counter.

Ports:
- clk  in  1  system clock; at least 8x the ssp_clk rate.
- rst  in  1  synchronous, active-high reset.
- ssp_clk  in  1  serial clock from the correlator; asynchronous to clk.
- ssp_frame  in  1  high during the first bit of each byte.
- ssp_din  in  1  serial data, MSB first; changes on ssp_clk rise.
- snoop  in  1  stream format select; static while running.
- resync  in  1  single-cycle pulse; drops the partial byte and pair, next byte is treated as I.
- out_valid  out  1  FIFO head holds a sample.
- out_ready  in  1  consumer accepts the head when out_valid is also high.
- out_i  out  8  signed I value.
- out_q  out  8  signed Q value.
- out_mag  out  9  unsigned approximate magnitude.
- out_reader  out  2  snoop reader bits {older, newer}; 0 when snoop is 0.
- overflow  out  1  sticky; set when a pair is dropped because the FIFO is full.
- frame_err_cnt  out  ERR_CNT_W  saturating count of framing errors.

Behaviour:
- Reset values: out_valid=0, out_i=0, out_q=0, out_mag=0, out_reader=0, overflow=0, frame_err_cnt=0. FIFO is emptied, byte_sel=I, FSM=HUNT. Reset takes effect from any state, including mid-byte or mid-pair.
- Sampling: all three SSP lines pass through SYNC_STAGES flip-flops. A bit is sampled on the clk cycle where a falling edge of synchronized ssp_clk is detected (previous=1, current=0). That cycle samples the synchronized ssp_frame and ssp_din together.
- FSM state HUNT:
  - Sample with frame=1: shreg={7'b0,din}, bitcnt=1, go to SHIFT.
  - Sample with frame=0: discard the bit and stay in HUNT. If this is the first bit after a completed byte, increment frame_err_cnt.
- FSM state SHIFT:
  - Sample with frame=0: shift din in at the LSB and increment bitcnt.
  - When bitcnt reaches 8, the byte completes that cycle and the FSM returns to HUNT.
  - Sample with frame=1 while bitcnt<8: increment frame_err_cnt, discard the partial byte, restart with this bit as the MSB (bitcnt=1), reset byte_sel to I.
- Pairing: completed bytes alternate I, Q, starting with I after reset or resync. Completing the Q byte forms a pair.
- Format with snoop=0: out_i=I byte, out_q=Q byte, out_reader=2'b00.
- Format with snoop=1: out_i={I[7],I[7:1]}, out_q={Q[7],Q[7:1]} (7-bit signed values, sign-extended). out_reader={I[0],Q[0]}.
- Magnitude: a=|out_i|, b=|out_q|, each 8-bit unsigned (|-128|=128). out_mag = max(a,b) + (min(a,b)>>1). Maximum value 192; no saturation needed.
- Push timing: the formatted pair is pushed into the FIFO exactly 1 clk after the Q byte completes.
  - If the FIFO was empty, out_valid rises in the same cycle as the push.
  - Total latency from the Q-byte's 8th ssp_clk fall to out_valid is SYNC_STAGES+2 clk cycles.
- FIFO full on push: the new pair is dropped, the head is kept, overflow is set. overflow clears only on rst.
- Simultaneous push and pop while full: the pop frees a slot and the push is accepted (no overflow).
- Handshake: outputs show the FIFO head and are stable while out_valid=1 and out_ready=0. A pop happens on out_valid&out_ready.
- resync: same cycle as a sample → resync wins; the sample is discarded and the FSM goes to HUNT. resync never flushes the FIFO.
- frame_err_cnt saturates at all-ones.

Test Plan:
- snoop=0, stream I=0x9C, Q=0x23, each with frame on its MSB → out_i=0x9C (-100), out_q=0x23 (35), out_mag=100+17=117, out_reader=0, latency SYNC_STAGES+2.
- snoop=1, I=0x81, Q=0x7E → out_i=0xC0 (-64), out_q=0x3F (63), out_reader=2'b10, out_mag=64+31=95.
- I=0x80, Q=0x80 with snoop=0 → out_mag=128+64=192; confirms |-128| handling.
- Hold out_ready=0 and send 6 pairs with FIFO_DEPTH=4 → first 4 pairs retained in order, overflow=1. Then release out_ready → exactly 4 pops.
- Assert frame at bit 5 of a byte → frame_err_cnt=1, the following 8 bits form a valid I byte. Also send a byte that lacks frame → frame_err_cnt increments and no output is produced.
- Assert rst mid-Q-byte, then send a fresh I/Q pair → all outputs are 0 during reset, the first byte after reset is taken as I, and the pair outputs correctly.
